uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that is the downstream counterpart of the team's serial transmitter. It recovers 8N1 frames from the asynchronous serial line using the shared 16x-oversampling baud tick, and delivers each byte as a one-cycle valid pulse to the consumer, such as the command decoder or ALU interface. It reports framing errors and, when configured, parity errors.

## Interface
- NB_DATA, 8, data bits per frame (LSB first)
- SAMPLE_MID, 7, tick index (0..15) within a bit period at which the line is sampled
- i_clk  input  1  system clock; all state updates on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_tick  input  1  one-cycle pulse at 16x baud rate, from the baud generator
- i_rx  input  1  serial line, asynchronous to i_clk, idle high
- o_data  output  NB_DATA  last received byte; held until the next frame completes
- o_valid  output  1  one-cycle pulse: o_data updated with a good or bad frame
- o_frame_err  output  1  one-cycle pulse coincident with o_valid when the stop bit sampled 0
- o_parity_err  output  1  one-cycle pulse coincident with o_valid on parity mismatch; constant 0 when parity is compiled out

## Operation
- i_rx passes through a 2-FF synchronizer, giving rx_s. A third register holds rx_q, the previous rx_s, for falling-edge detection.
- One-hot FSM with states IDLE, START, DATA, PARITY, STOP. There is a 4-bit tick counter and a bit counter of width clog2(NB_DATA)+1.
- IDLE: counters are 0. When rx_s==0 and rx_q==1 (a falling edge), go to START.
  - A line held low does not re-trigger, so a break condition produces one frame error only.
- START: on each i_tick, increment the tick counter.
  - At tick count SAMPLE_MID: if rx_s==0, go to DATA and clear the tick counter.
  - At tick count SAMPLE_MID: if rx_s==1, treat it as a glitch and return to IDLE with no outputs.
- DATA: on each i_tick, the tick counter increments mod 16.
  - At count 15, shift rx_s into the MSB of the shift register (right shift), so the LSB arrives first, and increment the bit counter.
  - After NB_DATA bits, go to PARITY if it is compiled in, else STOP.
- PARITY: sample at count 15 as in DATA, then go to STOP.
- STOP: sample at count 15. In the same clock:
  - o_data <= shift register
  - o_valid <= 1
  - o_frame_err <= (rx_s==0)
  - o_parity_err <= mismatch
  - next state is IDLE
- Return to IDLE happens at mid-stop-bit, so back-to-back frames from a transmitter with a 1-bit stop are received without loss.
- A bad frame still updates o_data and pulses o_valid; the consumer decides whether to discard it.
- i_tick is ignored in IDLE. Edge detection runs on every i_clk.

## Timing
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, FSM=IDLE, counters=0, synchronizer and rx_q=1.
- Asserting i_reset mid-frame aborts the frame immediately (asynchronously) with no o_valid. After deassertion, the next falling edge starts a new frame.
- Input latency: 2 i_clk cycles from i_rx to rx_s, plus 1 cycle to edge detect.
- o_valid rises on the i_clk edge after the i_tick that samples the stop bit, and stays high exactly 1 cycle.
- Frame duration, start edge to o_valid, is (SAMPLE_MID+1) + 16*(NB_DATA+1+P) ticks, where P=1 with parity and 0 without. For the defaults with no parity, that is 152 ticks plus synchronizer delay.
- If i_tick is asserted on consecutive cycles, every pulse counts; there is no rate limiting.

## Configuration
- UART_RX_PARITY_EN defined: an even parity bit is expected between the data and stop bits. The PARITY state exists. o_parity_err = (XOR of data bits) ^ parity bit.
- UART_RX_PARITY_EN undefined: the PARITY state and its logic are absent, the frame is 8N1, and o_parity_err is tied 0. The port list is identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - state encodings for IDLE, START, DATA, PARITY, STOP
  - OVERSAMPLE=16
  - default NB_DATA=8
  - default SAMPLE_MID=7
- The package is reused by the transmitter and the baud generator.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with async active-low reset and a reset value parameter (1 here).

## Test plan
- Reset: hold i_reset=0 with i_rx toggling. All outputs stay 0. Release, send 0xA5 (8N1) → one o_valid pulse, o_data=0xA5, o_frame_err=0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap → three o_valid pulses, bytes in order, no errors.
- Glitch: drive i_rx low for 4 ticks, then high → no o_valid, FSM returns to IDLE. A following 0x55 is received correctly.
- Framing: send 0x81 with the stop bit forced 0 → o_valid=1, o_frame_err=1, o_data=0x81. Holding the line low afterwards produces no further pulses.
- Reset mid-frame: assert i_reset during data bit 4 of 0xC3 → no o_valid. The next frame 0x12 is received correctly.
- Parity (UART_RX_PARITY_EN): send 0x07 with parity bit 1 → o_parity_err=0. Send 0x07 with parity bit 0 → o_parity_err=1, o_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling factor and frame defaults.
// Reused by the transmitter, the baud generator and the receiver.
package uart_pkg;
  localparam int OVERSAMPLE      = 16;
  localparam int NB_DATA_DFLT    = 8;
  localparam int SAMPLE_MID_DFLT = 7;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with async active-low reset and configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1 by default); delivers each byte as a one-cycle valid pulse.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DFLT,
  parameter int SAMPLE_MID = SAMPLE_MID_DFLT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_parity_err
);
  localparam int BW = $clog2(NB_DATA) + 1;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic               rx_s, rx_q;
  state_t             state_q, state_d;
  logic [3:0]         tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               done, par_err;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (i_clk),
    .rst_n(i_reset),
    .d    (i_rx),
    .q    (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_q, par_d;
  assign par_err = (^shift_q) ^ par_q;
`else
  localparam state_t AFTER_DATA = STOP;
  assign par_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_q    <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      rx_q    <= rx_s;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        // Edge-triggered so a line stuck low (break) cannot restart frames.
        if (!rx_s && rx_q) state_d = START;
      end
      START: if (i_tick) begin
        if (tick_q == 4'(SAMPLE_MID)) begin
          tick_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end
      DATA: if (i_tick) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == LAST_TICK) begin
          shift_d = {rx_s, shift_q[NB_DATA-1:1]};
          if (bit_q == BW'(NB_DATA - 1)) begin
            bit_d   = '0;
            state_d = AFTER_DATA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (i_tick) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == LAST_TICK) begin
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: if (i_tick) begin
        tick_d = tick_q + 4'd1;
        // Leave at mid-stop so a following start edge is never missed.
        if (tick_q == LAST_TICK) begin
          done    = 1'b1;
          tick_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_valid      <= done;
      o_frame_err  <= done & ~rx_s;
      o_parity_err <= done & par_err;
      if (done) o_data <= shift_q;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level scoreboard model plus literal pins on held data and pulse counts.
module tb_uart_rx;
  localparam int TPB    = 4;        // clocks per 16x tick
  localparam int BITCLK = 16 * TPB; // clocks per serial bit
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err;

  always #5 i_clk = ~i_clk;

  uart_rx dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t expq[$];
  int vectors = 0, miscompares = 0;
  int nvalid = 0, nferr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge i_clk);
      c++;
      i_tick = (c % TPB == 0);
    end
  end

  // Every cycle: a valid pulse must match the oldest expected frame, otherwise no error flags.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_valid) begin
      nvalid++;
      if (o_frame_err) nferr++;
      if (expq.size() == 0) chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
      else begin
        e = expq.pop_front();
        chk("data", {24'd0, o_data}, {24'd0, e.d});
        chk("frame_err", {31'd0, o_frame_err}, {31'd0, e.fe});
        chk("parity_err", {31'd0, o_parity_err}, {31'd0, e.pe});
      end
    end else begin
      chk("err_idle", {30'd0, o_frame_err, o_parity_err}, 32'd0);
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_inv,
                            input bit expect_it);
    logic [11:0] bits;
    int n;
    exp_t e;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (PAR_EN) begin bits[n] = (^d) ^ par_inv; n++; end
    bits[n] = stop_v; n++;
    if (expect_it) begin
      e.d  = d;
      e.fe = ~stop_v;
      e.pe = PAR_EN & par_inv;
      expq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      i_rx = bits[i];
      repeat (BITCLK) @(negedge i_clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && expq.size() != 0; i++) @(negedge i_clk);
    chk("pending_frames", expq.size(), 32'd0);
    expq.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a toggling line: all outputs stay 0.
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      i_rx = i[2];
      chk("rst_outputs", {21'd0, o_data, o_valid, o_frame_err, o_parity_err}, 32'd0);
    end
    i_rx = 1'b1;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (100) @(negedge i_clk);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    drain();
    chk("a5_hold", {24'd0, o_data}, 32'h0000_00A5);
    chk("a5_count", nvalid, 32'd1);

    // Back-to-back, single stop bit, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    drain();
    chk("b2b_hold", {24'd0, o_data}, 32'h0000_003C);
    chk("b2b_count", nvalid, 32'd4);
    chk("b2b_ferr", nferr, 32'd0);

    // Glitch: low for 4 ticks only.
    i_rx = 1'b0;
    repeat (4 * TPB) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (3 * BITCLK) @(negedge i_clk);
    chk("glitch_count", nvalid, 32'd4);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    drain();
    chk("55_hold", {24'd0, o_data}, 32'h0000_0055);

    // Framing error, then line held low (break).
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (3 * BITCLK) @(negedge i_clk);
    drain();
    chk("break_count", nvalid, 32'd6);
    chk("break_ferr", nferr, 32'd1);
    chk("81_hold", {24'd0, o_data}, 32'h0000_0081);
    i_rx = 1'b1;
    repeat (2 * BITCLK) @(negedge i_clk);

    // Reset asserted during data bit 4, held until the line is idle again.
    fork
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5 * BITCLK + BITCLK / 2) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("midrst_outputs", {21'd0, o_data, o_valid, o_frame_err, o_parity_err}, 32'd0);
      end
    join
    repeat (10) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (50) @(negedge i_clk);
    chk("midrst_count", nvalid, 32'd6);
    send_frame(8'h12, 1'b1, 1'b0, 1'b1);
    drain();
    chk("12_hold", {24'd0, o_data}, 32'h0000_0012);
    chk("12_count", nvalid, 32'd7);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    drain();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    drain();
    chk("par_count", nvalid, 32'd9);
`endif

    repeat (200) @(negedge i_clk);
    chk("leftover", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
